// File: rtl/mod_sub_ecc.sv
// rtl/mod_sub_ecc.sv - multi-cycle limb-serial modular subtractor (a - b) mod p
// One W-bit limb per clock with a rippled borrow, then an optional add-back pass of p.
module mod_sub_ecc #(
   parameter int W = 64,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W*N-1:0] a,
   input  logic [W*N-1:0] b,
   input  logic [W*N-1:0] p,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W*N-1:0] diff,
   output logic           corrected
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SUB, S_CORR, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [W*N-1:0] r_a;
   logic [W*N-1:0] r_b;
   logic [W*N-1:0] r_p;
   logic [W*N-1:0] r_diff;
   logic [IW-1:0]  r_idx;
   logic           r_bc;
   logic           r_corrected;

   logic [W-1:0]   w_a_l;
   logic [W-1:0]   w_b_l;
   logic [W-1:0]   w_p_l;
   logic [W-1:0]   w_d_l;
   logic [W:0]     w_sub;
   logic [W:0]     w_add;
   logic           w_last;
   logic           w_accept;

   assign w_a_l    = r_a[r_idx*W +: W];
   assign w_b_l    = r_b[r_idx*W +: W];
   assign w_p_l    = r_p[r_idx*W +: W];
   assign w_d_l    = r_diff[r_idx*W +: W];
   assign w_sub    = {1'b0, w_a_l} - {1'b0, w_b_l} - {{W{1'b0}}, r_bc};
   assign w_add    = {1'b0, w_d_l} + {1'b0, w_p_l} + {{W{1'b0}}, r_bc};
   assign w_last   = (r_idx == IW'(N - 1));
   assign w_accept = in_valid && in_ready;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign diff      = r_diff;
   assign corrected = r_corrected;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_SUB;
         S_SUB:  if (w_last) w_next = w_sub[W] ? S_CORR : S_DONE;
         S_CORR: if (w_last) w_next = S_DONE;
         S_DONE: if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Operand latches need no reset: they are only read after an accept loads them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= a;
         r_b <= b;
         r_p <= p;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_diff      <= '0;
         r_idx       <= '0;
         r_bc        <= 1'b0;
         r_corrected <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_idx       <= '0;
                  r_bc        <= 1'b0;
                  r_corrected <= 1'b0;
               end
            end
            S_SUB: begin
               r_diff[r_idx*W +: W] <= w_sub[W-1:0];
               if (w_last) begin
                  r_idx       <= '0;
                  r_bc        <= 1'b0;
                  r_corrected <= w_sub[W];
               end else begin
                  r_idx <= r_idx + IW'(1);
                  r_bc  <= w_sub[W];
               end
            end
            S_CORR: begin
               // Final carry out of the top limb is the 2^(W*N) wrap and is dropped.
               r_diff[r_idx*W +: W] <= w_add[W-1:0];
               if (w_last) begin
                  r_idx <= '0;
                  r_bc  <= 1'b0;
               end else begin
                  r_idx <= r_idx + IW'(1);
                  r_bc  <= w_add[W];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_sub_ecc.sv
// tb/tb_mod_sub_ecc.sv - directed scoreboard bench for mod_sub_ecc
module tb_mod_sub_ecc;

   localparam int W  = 64;
   localparam int N  = 4;
   localparam int WN = W * N;
   localparam logic [WN-1:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [WN-1:0] a;
   logic [WN-1:0] b;
   logic [WN-1:0] p;
   logic          out_valid;
   logic          out_ready;
   logic [WN-1:0] diff;
   logic          corrected;

   typedef struct {
      logic [WN-1:0] d;
      logic          c;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mod_sub_ecc #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .p         (p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .corrected (corrected)
   );

   task automatic check(input string tag, input logic [WN-1:0] obs, input logic [WN-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_model(input logic [WN-1:0] av, input logic [WN-1:0] bv);
      logic [WN:0] t;
      exp_t        e;
      t     = {1'b0, av} - {1'b0, bv};
      e.c   = t[WN];
      e.d   = t[WN-1:0] + (e.c ? P : '0);
      e.lat = e.c ? 2 * N : N;
      sb.push_back(e);
   endtask

   function automatic logic [WN-1:0] rand256();
      logic [WN-1:0] r;
      r = '0;
      for (int k = 0; k < WN / 32; k++) r = {r[WN-33:0], 32'($urandom())};
      return r;
   endfunction

   // Returns at the falling edge just after the accepting edge, with the inputs scrambled.
   task automatic accept(input logic [WN-1:0] av, input logic [WN-1:0] bv, input bit push);
      int k;
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      if (push) push_model(av, bv);
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", {255'b0, in_ready}, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~av;
      b        = ~bv;
   endtask

   task automatic wait_out(input string tag);
      int   lat;
      exp_t e;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_sb_nonempty"}, {255'b0, (sb.size() != 0)}, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_latency"}, WN'(lat), WN'(e.lat));
         check({tag, "_diff"}, diff, e.d);
         check({tag, "_corrected"}, {255'b0, corrected}, {255'b0, e.c});
      end
   endtask

   task automatic run_op(input string tag, input logic [WN-1:0] av, input logic [WN-1:0] bv);
      out_ready = 1'b1;
      accept(av, bv, 1'b1);
      wait_out(tag);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle_ready"}, {255'b0, in_ready}, 1);
      check({tag, "_idle_valid"}, {255'b0, out_valid}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      p         = P;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {255'b0, out_valid}, 0);
      check("rst_diff", diff, 0);
      check("rst_corrected", {255'b0, corrected}, 0);
      check("rst_in_ready", {255'b0, in_ready}, 1);
      rst_n = 1'b1;

      run_op("no_borrow", 5, 3);
      run_op("wrap", 3, 5);
      check("wrap_value", diff, P - 2);
      run_op("equal", 256'h1234, 256'h1234);
      run_op("interlimb", 256'h1 << 64, 1);
      check("interlimb_value", diff, 256'hFFFFFFFF_FFFFFFFF);

      // Backpressure with a pending new request held on the input side.
      out_ready = 1'b0;
      accept(10, 4, 1'b1);
      wait_out("bp");
      in_valid = 1'b1;
      a        = 100;
      b        = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_diff", diff, 6);
         check("bp_hold_valid", {255'b0, out_valid}, 1);
         check("bp_hold_in_ready", {255'b0, in_ready}, 0);
         check("bp_hold_corrected", {255'b0, corrected}, 0);
      end
      out_ready = 1'b1;
      push_model(100, 1);
      @(posedge clk);
      @(negedge clk);
      check("bp_after_hs_ready", {255'b0, in_ready}, 1);
      check("bp_after_hs_valid", {255'b0, out_valid}, 0);
      @(posedge clk);
      @(negedge clk);
      check("bp_next_taken", {255'b0, in_ready}, 0);
      in_valid = 1'b0;
      wait_out("bp_next");
      @(posedge clk);
      @(negedge clk);

      // Reset pulse during the second SUB cycle aborts the operation.
      out_ready = 1'b1;
      accept(20, 30, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_in_ready", {255'b0, in_ready}, 1);
      check("midrst_out_valid", {255'b0, out_valid}, 0);
      check("midrst_diff", diff, 0);
      check("midrst_corrected", {255'b0, corrected}, 0);
      run_op("after_rst", 7, 9);
      check("after_rst_value", diff, P - 2);

      for (int k = 0; k < 4; k++) begin
         run_op("random", rand256(), rand256());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_sub_ecc.md
# mod_sub_ecc

Multi-cycle modular subtractor for ECC prime-field arithmetic. It computes diff = (a − b) mod p on N-limb operands, processing one W-bit limb per clock with a rippled borrow, then applies a conditional add-back of p. It is the inverse-direction companion to the field adder datapath. It sits beside the modular adder in the point add/double unit and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- W, 64, limb width in bits
- N, 4, limbs per operand (field width W*N = 256 by default)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- in_valid  in  1  operands a, b, p are valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  W*N  minuend; precondition a < p
- b  in  W*N  subtrahend; precondition b < p
- p  in  W*N  field prime modulus
- out_valid  out  1  diff is valid
- out_ready  in  1  downstream accepts diff
- diff  out  W*N  result (a − b) mod p
- corrected  out  1  1 when the add-back of p was applied (a < b)

## Operation
- FSM states: IDLE, SUB, CORR, DONE.
- IDLE: in_ready = 1. When in_valid && in_ready at an edge, latch a, b, p, clear limb index i and the borrow, and go to SUB.
- SUB, one limb per cycle: {bw, d[i]} = a[i] − b[i] − bw, computed at W+1 bits, with limb 0 as the LSB.
  - Store d[i] into the result register and increment i.
  - After limb N−1, inspect the final borrow:
    - borrow = 0: go to DONE with corrected = 0.
    - borrow = 1: clear i, clear carry, set corrected = 1, and go to CORR.
- CORR, one limb per cycle: {c, d[i]} = d[i] + p[i] + c. After limb N−1, discard the final carry and go to DONE.
- DONE: out_valid = 1. diff and corrected are held stable until out_valid && out_ready, then return to IDLE on that edge.
- Arithmetic: modulo-2^W per limb; borrow and carry are 1 bit.
- Precondition violations (a ≥ p or b ≥ p): the result is still the documented two-pass value, (a − b) mod 2^(W·N), plus p if a borrow occurred, modulo 2^(W·N). No error flag is raised.
- No pipelining: exactly one operation is in flight. in_valid is ignored outside IDLE.
- Latched operands are internal. Input changes after acceptance have no effect.

## Timing
- Reset (rst_n low at an edge) has these effects:
  - state = IDLE
  - out_valid = 0
  - diff = 0
  - corrected = 0
  - i, borrow and carry cleared
- in_ready is decoded from state, so it is 1 from the first edge after reset.
- Reset mid-operation (SUB, CORR or DONE) aborts the operation with no output. The next operation behaves normally.
- Latency, counting the accepting edge as edge 0:
  - no correction: out_valid first high after edge N (4 cycles by default);
  - correction applied: out_valid first high after edge 2N (8 cycles by default).
- Back-to-back: the earliest the next accept can occur is the edge after the out handshake edge. in_ready rises in the cycle following that handshake.
- While out_ready is low in DONE, all outputs stay constant.
- Throughput: at most one result per N+2 cycles without correction, or per 2N+2 cycles with correction.

## Test plan
Unless stated otherwise, use W = 64, N = 4 and p = secp256k1 prime 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F.

- No borrow: a = 5, b = 3, out_ready held high -> diff = 2, corrected = 0, out_valid high exactly 4 cycles after accept.
- Wrap-around: a = 3, b = 5 -> diff = p − 2 = 0x…FFFFFFFE_FFFFFC2D, corrected = 1, out_valid high 8 cycles after accept.
- Equal operands: a = b = 0x1234 -> diff = 0, corrected = 0.
- Inter-limb borrow: a = 2^64, b = 1 -> diff limb0 = 0xFFFFFFFF_FFFFFFFF, limbs 1..3 = 0, corrected = 0.
- Backpressure:
  - Stimulus: a = 10, b = 4, out_ready low for 5 cycles in DONE, with in_valid held high carrying new operands.
  - Response: diff = 6 stable throughout, in_ready = 0, and the new operands are not taken.
  - After out_ready goes high: handshake, then the new operands are accepted the following cycle.
- Reset mid-operation: pulse rst_n low for 1 cycle at cycle 2 of SUB -> next cycle state IDLE, out_valid = 0, diff = 0, in_ready = 1. A subsequent a = 7, b = 9 yields diff = p − 2, corrected = 1.
